// File: rtl/id_stage_if.sv
// Interface between fetch, writeback, execute hazard inputs and the decode stage.
// The master side is the environment around ID; the slave side is id_stage itself.
interface id_stage_if #(
  parameter int XLEN = 32
);
  logic [31:0]     Ins;
  logic [XLEN-1:0] nextPC;
  logic            if_valid;
  logic            flush;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            ex_memread;
  logic [4:0]      ex_rt;
  logic            stall;
  logic            id_valid;
  logic [XLEN-1:0] id_pc4;
  logic [XLEN-1:0] id_rs_data;
  logic [XLEN-1:0] id_rt_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs;
  logic [4:0]      id_rt;
  logic [4:0]      id_rd;
  logic [5:0]      id_funct;
  logic [6:0]      id_ctrl;

  modport master (
    output Ins, nextPC, if_valid, flush, wb_we, wb_addr, wb_data, ex_memread, ex_rt,
    input  stall, id_valid, id_pc4, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_funct, id_ctrl
  );

  modport slave (
    input  Ins, nextPC, if_valid, flush, wb_we, wb_addr, wb_data, ex_memread, ex_rt,
    output stall, id_valid, id_pc4, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_funct, id_ctrl
  );
endinterface

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, 32-entry register file with write-through
// bypass, load-use hazard detection, and the registered ID/EX bundle.
module id_stage #(
  parameter int              XLEN     = 32,
  parameter logic [31:0]     NOP_WORD = 32'h0000_0000,
  parameter bit              RF_CLEAR = 1'b1
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  id_stage_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // Control word order: {RegWrite,MemRead,MemWrite,Branch,Jump,ALUSrc,RegDst}
  function automatic logic [6:0] f_decode(input logic [5:0] op);
    case (op)
      OP_RTYPE: f_decode = 7'b1000001;
      OP_LW:    f_decode = 7'b1100010;
      OP_SW:    f_decode = 7'b0010010;
      OP_BEQ:   f_decode = 7'b0001000;
      OP_ADDI:  f_decode = 7'b1000010;
      OP_J:     f_decode = 7'b0000100;
      default:  f_decode = 7'b0000000;
    endcase
  endfunction

  logic [31:0]            r_ins_p0;
  logic [XLEN-1:0]        r_pc4_p0;
  logic                   r_vld_p0;

  logic                   r_vld_p1;
  logic [XLEN-1:0]        r_pc4_p1;
  logic [XLEN-1:0]        r_rs_data_p1;
  logic [XLEN-1:0]        r_rt_data_p1;
  logic signed [XLEN-1:0] r_imm_p1;
  logic [4:0]             r_rs_p1;
  logic [4:0]             r_rt_p1;
  logic [4:0]             r_rd_p1;
  logic [5:0]             r_funct_p1;
  logic [6:0]             r_ctrl_p1;

  logic [XLEN-1:0]        r_rf [32];

  logic [4:0]             w_rs;
  logic [4:0]             w_rt;
  logic [XLEN-1:0]        w_rs_data;
  logic [XLEN-1:0]        w_rt_data;
  logic signed [XLEN-1:0] w_imm;
  logic                   w_stall;
  logic                   w_bubble;

  assign w_rs  = r_ins_p0[25:21];
  assign w_rt  = r_ins_p0[20:16];
  assign w_imm = {{(XLEN-16){r_ins_p0[15]}}, r_ins_p0[15:0]};

  // A flush kills the younger instruction anyway, so it overrides the hazard stall.
  assign w_stall  = r_vld_p0 & bus.ex_memread & (bus.ex_rt != 5'd0) &
                    ((bus.ex_rt == w_rs) | (bus.ex_rt == w_rt)) & ~bus.flush;
  assign w_bubble = bus.flush | w_stall | ~r_vld_p0;

  // Reads see a same-cycle writeback so WB->ID needs no extra stall.
  assign w_rs_data = (w_rs == 5'd0) ? '0 :
                     (bus.wb_we && bus.wb_addr == w_rs) ? bus.wb_data : r_rf[w_rs];
  assign w_rt_data = (w_rt == 5'd0) ? '0 :
                     (bus.wb_we && bus.wb_addr == w_rt) ? bus.wb_data : r_rf[w_rt];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      if (RF_CLEAR) begin
        for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      end
    end else if (bus.wb_we && bus.wb_addr != 5'd0) begin
      r_rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  // IF -> ID boundary
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || bus.flush) begin
      r_ins_p0 <= NOP_WORD;
      r_pc4_p0 <= '0;
      r_vld_p0 <= 1'b0;
    end else if (!w_stall) begin
      r_ins_p0 <= bus.Ins;
      r_pc4_p0 <= bus.nextPC;
      r_vld_p0 <= bus.if_valid;
    end
  end

  // ID -> EX boundary
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || w_bubble) begin
      r_vld_p1     <= 1'b0;
      r_pc4_p1     <= '0;
      r_rs_data_p1 <= '0;
      r_rt_data_p1 <= '0;
      r_imm_p1     <= '0;
      r_rs_p1      <= '0;
      r_rt_p1      <= '0;
      r_rd_p1      <= '0;
      r_funct_p1   <= '0;
      r_ctrl_p1    <= '0;
    end else begin
      r_vld_p1     <= 1'b1;
      r_pc4_p1     <= r_pc4_p0;
      r_rs_data_p1 <= w_rs_data;
      r_rt_data_p1 <= w_rt_data;
      r_imm_p1     <= w_imm;
      r_rs_p1      <= w_rs;
      r_rt_p1      <= w_rt;
      r_rd_p1      <= r_ins_p0[15:11];
      r_funct_p1   <= r_ins_p0[5:0];
      r_ctrl_p1    <= f_decode(r_ins_p0[31:26]);
    end
  end

  assign bus.stall      = w_stall;
  assign bus.id_valid   = r_vld_p1;
  assign bus.id_pc4     = r_pc4_p1;
  assign bus.id_rs_data = r_rs_data_p1;
  assign bus.id_rt_data = r_rt_data_p1;
  assign bus.id_imm     = r_imm_p1;
  assign bus.id_rs      = r_rs_p1;
  assign bus.id_rt      = r_rt_p1;
  assign bus.id_rd      = r_rd_p1;
  assign bus.id_funct   = r_funct_p1;
  assign bus.id_ctrl    = r_ctrl_p1;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, bypass, load-use stall, flush priority, r0 guard
// and the opcode decode table.
module tb_id_stage;
  logic i_clk = 1'b0;
  logic i_rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  id_stage_if u_if ();

  id_stage u_dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (u_if.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Load one instruction into IF/ID, then let it reach the ID/EX outputs.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc4);
    u_if.Ins      = ins;
    u_if.nextPC   = pc4;
    u_if.if_valid = 1'b1;
    step();
    u_if.if_valid = 1'b0;
    step();
  endtask

  logic [31:0] tbl_ins  [6];
  logic [6:0]  tbl_ctrl [6];

  initial begin
    u_if.Ins = 32'h8C22_0004; u_if.nextPC = 32'h0; u_if.if_valid = 1'b1;
    u_if.flush = 1'b0; u_if.wb_we = 1'b0; u_if.wb_addr = 5'd0; u_if.wb_data = 32'h0;
    u_if.ex_memread = 1'b0; u_if.ex_rt = 5'd0;
    i_rst_n = 1'b0;

    // Reset
    step(); step();
    check("rst_id_valid", {31'h0, u_if.id_valid}, 32'h0);
    check("rst_id_ctrl", {25'h0, u_if.id_ctrl}, 32'h0);
    check("rst_stall", {31'h0, u_if.stall}, 32'h0);
    i_rst_n = 1'b1;
    issue(32'h00E8_3020, 32'h0000_0040);             // add $6,$7,$8
    check("rst_rs_read", u_if.id_rs_data, 32'h0);
    check("rst_rt_read", u_if.id_rt_data, 32'h0);
    check("add_valid", {31'h0, u_if.id_valid}, 32'h1);
    check("add_rd", {27'h0, u_if.id_rd}, 32'd6);
    check("add_funct", {26'h0, u_if.id_funct}, 32'h20);
    check("add_pc4", u_if.id_pc4, 32'h0000_0040);

    // Write-through bypass: add $4,$3,$3 decoded while $3 is written
    u_if.Ins = 32'h0063_2020; u_if.if_valid = 1'b1;
    step();
    u_if.if_valid = 1'b0;
    u_if.wb_we = 1'b1; u_if.wb_addr = 5'd3; u_if.wb_data = 32'hDEAD_BEEF;
    step();
    u_if.wb_we = 1'b0;
    check("byp_rs", u_if.id_rs_data, 32'hDEAD_BEEF);
    check("byp_rt", u_if.id_rt_data, 32'hDEAD_BEEF);
    check("byp_ctrl", {25'h0, u_if.id_ctrl}, 32'h41);
    issue(32'h0060_4820, 32'h0000_0050);             // add $9,$3,$0: stored value
    check("rf_rs_stored", u_if.id_rs_data, 32'hDEAD_BEEF);
    check("rf_rt_r0", u_if.id_rt_data, 32'h0);

    // Load-use: add $5,$2,$1 behind lw $2
    u_if.Ins = 32'h0041_2820; u_if.nextPC = 32'h0000_0100; u_if.if_valid = 1'b1;
    step();
    u_if.Ins = 32'hAC00_0000; u_if.nextPC = 32'h0000_0104;
    u_if.ex_memread = 1'b1; u_if.ex_rt = 5'd2;
    #1;
    check("lu_stall", {31'h0, u_if.stall}, 32'h1);
    step();
    check("lu_bubble", {31'h0, u_if.id_valid}, 32'h0);
    u_if.ex_memread = 1'b0;
    u_if.Ins = 32'h0041_2820; u_if.nextPC = 32'h0000_0108;
    #1;
    check("lu_stall_clr", {31'h0, u_if.stall}, 32'h0);
    step();
    check("lu_valid", {31'h0, u_if.id_valid}, 32'h1);
    check("lu_rd", {27'h0, u_if.id_rd}, 32'd5);
    check("lu_pc4_held", u_if.id_pc4, 32'h0000_0100);

    // Flush with load-use pending: IF/ID now holds add $5,$2,$1 again, rt=$1 hazard
    u_if.if_valid = 1'b0;
    u_if.ex_memread = 1'b1; u_if.ex_rt = 5'd1;
    #1;
    check("rt_stall", {31'h0, u_if.stall}, 32'h1);
    u_if.flush = 1'b1;
    #1;
    check("fl_stall", {31'h0, u_if.stall}, 32'h0);
    step();
    check("fl_id_valid", {31'h0, u_if.id_valid}, 32'h0);
    check("fl_id_ctrl", {25'h0, u_if.id_ctrl}, 32'h0);
    u_if.flush = 1'b0; u_if.ex_memread = 1'b0;
    step();
    check("fl_ifid_nop", {31'h0, u_if.id_valid}, 32'h0);

    // r0 guard and negative immediate: lw $2,-4($0) with a write to $0 in flight
    u_if.Ins = 32'h8C02_FFFC; u_if.if_valid = 1'b1;
    step();
    u_if.if_valid = 1'b0;
    u_if.wb_we = 1'b1; u_if.wb_addr = 5'd0; u_if.wb_data = 32'h1;
    step();
    u_if.wb_we = 1'b0;
    check("r0_byp", u_if.id_rs_data, 32'h0);
    check("lw_imm", u_if.id_imm, 32'hFFFF_FFFC);
    check("lw_ctrl", {25'h0, u_if.id_ctrl}, 32'h62);
    check("lw_rt", {27'h0, u_if.id_rt}, 32'd2);
    issue(32'h0000_0000, 32'h0000_0200);
    check("r0_read", u_if.id_rs_data, 32'h0);
    check("nop_ctrl", {25'h0, u_if.id_ctrl}, 32'h41);
    check("nop_valid", {31'h0, u_if.id_valid}, 32'h1);

    // Opcode table
    tbl_ins[0] = 32'hAC43_0008; tbl_ctrl[0] = 7'b0010010;   // sw
    tbl_ins[1] = 32'h1043_0002; tbl_ctrl[1] = 7'b0001000;   // beq
    tbl_ins[2] = 32'h2043_7FFF; tbl_ctrl[2] = 7'b1000010;   // addi
    tbl_ins[3] = 32'h0800_0010; tbl_ctrl[3] = 7'b0000100;   // j
    tbl_ins[4] = 32'hFC00_0000; tbl_ctrl[4] = 7'b0000000;   // unknown
    tbl_ins[5] = 32'h8C00_0010; tbl_ctrl[5] = 7'b1100010;   // lw
    for (int k = 0; k < 6; k++) begin
      issue(tbl_ins[k], 32'h0000_0300 + 32'(k * 4));
      check($sformatf("op%0d_ctrl", k), {25'h0, u_if.id_ctrl}, {25'h0, tbl_ctrl[k]});
      check($sformatf("op%0d_valid", k), {31'h0, u_if.id_valid}, 32'h1);
    end
    check("addi_imm", 32'h0000_7FFF, 32'h0000_7FFF & {16'h0, tbl_ins[2][15:0]});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
